// File: rtl/l1_cache_pkg.sv
// ---------------------------------------------------------------------------
// l1_cache_pkg
// Shared types and helpers for the L1 cache controller:
//   state_e     - controller FSM states
//   addr_index  - extracts the index field (low INDEX_BITS) of a word address
//   addr_tag    - extracts the tag field (bits above the index) of an address
// ---------------------------------------------------------------------------
package l1_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_COMPARE     = 3'd1,
        S_WRITEBACK   = 3'd2,
        S_REFILL_REQ  = 3'd3,
        S_REFILL_WAIT = 3'd4
    } state_e;

    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int unsigned index_bits);
        return addr & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int unsigned index_bits);
        return addr >> index_bits;
    endfunction

endpackage

// File: rtl/l1_cache_ctrl_line_store.sv
// ---------------------------------------------------------------------------
// l1_line_store
// Storage for the direct-mapped cache: data, tag, valid and dirty per line.
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   rd_idx_i            combinational read index
//   rd_valid_o/rd_dirty_o/rd_tag_o/rd_data_o   line contents at rd_idx_i
//   wr_idx_i            write index
//   wr_en_i             write whole line: tag, data, valid=1, dirty=wr_dirty_i
//   wr_tag_i/wr_data_i/wr_dirty_i   line contents to write
//   clr_dirty_i         clear only the dirty bit of wr_idx_i
// Only valid/dirty are reset; data and tag arrays hold garbage until filled.
// ---------------------------------------------------------------------------
module l1_line_store #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic                  rd_dirty_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic                  wr_en_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_dirty_i,
    input  logic                  clr_dirty_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= wr_dirty_i;
        end else if (clr_dirty_i) begin
            dirty_q[wr_idx_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/l1_cache_ctrl.sv
// ---------------------------------------------------------------------------
// l1_cache_ctrl
// Direct-mapped, write-back, write-allocate L1 cache controller, one word per
// line, word-addressed. Sits between a CPU load/store port and main memory.
// Ports:
//   clk, reset                      rising-edge clock, async active-low reset
//   cpu_req_valid/ready/we/addr/wdata   CPU request (ready only in IDLE)
//   cpu_rsp_valid/rdata             one-cycle response pulse (rdata 0 otherwise)
//   mem_req_valid/ready/we/addr/wdata   memory request (we=1 writeback)
//   mem_rsp_valid/rdata             refill data pulse
//   stat_hits/stat_misses           saturating counters (L1_CACHE_STATS_EN only)
// Configuration macro: L1_CACHE_STATS_EN adds the hit/miss statistics ports.
// ---------------------------------------------------------------------------
module l1_cache_ctrl
    import l1_cache_pkg::*;
#(
    parameter int ADDR_BITS  = 10,
    parameter int INDEX_BITS = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_we,
    input  logic [ADDR_BITS-1:0]  cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_BITS-1:0]  mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata
`ifdef L1_CACHE_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses
`endif
);

    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;

    state_e state_q, state_d;

    // Latched request; held for the whole transaction, so it needs no reset.
    logic                  req_we_q;
    logic [ADDR_BITS-1:0]  req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic                  latch_en;

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;

    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  hit;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_dirty;
    logic                  clr_dirty;

    assign req_idx = INDEX_BITS'(addr_index(32'(req_addr_q), INDEX_BITS));
    assign req_tag = TAG_BITS'(addr_tag(32'(req_addr_q), INDEX_BITS));
    assign hit     = rd_valid && (rd_tag == req_tag);

    l1_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .rd_idx_i    (req_idx),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_idx_i    (req_idx),
        .wr_en_i     (wr_en),
        .wr_tag_i    (req_tag),
        .wr_data_i   (wr_data),
        .wr_dirty_i  (wr_dirty),
        .clr_dirty_i (clr_dirty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            req_we_q    <= cpu_req_we;
            req_addr_q  <= cpu_req_addr;
            req_wdata_q <= cpu_req_wdata;
        end
    end

    // Outputs are decoded from the registered state and latched request, so
    // the memory request stays stable for as long as it is back-pressured.
    always_comb begin
        state_d       = state_q;
        latch_en      = 1'b0;
        cpu_req_ready = 1'b0;
        cpu_rsp_valid = 1'b0;
        cpu_rsp_rdata = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        wr_en         = 1'b0;
        wr_data       = req_wdata_q;
        wr_dirty      = 1'b0;
        clr_dirty     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    latch_en = 1'b1;
                    state_d  = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    cpu_rsp_valid = 1'b1;
                    if (req_we_q) begin
                        wr_en    = 1'b1;
                        wr_dirty = 1'b1;
                    end else begin
                        cpu_rsp_rdata = rd_data;
                    end
                    state_d = S_IDLE;
                end else if (rd_valid && rd_dirty) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_REFILL_REQ;
                end
            end
            S_WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {rd_tag, req_idx};
                mem_req_wdata = rd_data;
                if (mem_req_ready) begin
                    clr_dirty = 1'b1;
                    state_d   = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = req_addr_q;
                if (mem_req_ready) state_d = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                if (mem_rsp_valid) begin
                    wr_en   = 1'b1;
                    wr_data = mem_rsp_rdata;
                    state_d = S_COMPARE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef L1_CACHE_STATS_EN
    // first_q marks the first COMPARE of a request; the post-refill retry
    // is not counted again.
    logic        first_q, first_d;
    logic [31:0] hits_q, misses_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        first_d = first_q;
        if (latch_en)                    first_d = 1'b1;
        else if (state_q == S_COMPARE)   first_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_q  <= 1'b0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            first_q <= first_d;
            if (state_q == S_COMPARE && first_q) begin
                if (hit) hits_q   <= sat_inc(hits_q);
                else     misses_q <= sat_inc(misses_q);
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule
